tanimoto_bist_src: RTL and testbench

// - Synthesizable stimulus source for tanimoto_top. Runs on-chip self-test and bring-up without a host.
// - On start, it performs three steps in order:
//   1. Loads the threshold BRAM.
//   2. Programs the compare-vector count through its handshake.
//   3. Streams REF_VEC_NO+CmpVecNo vectors, each SUB_VECTOR_NO bus words long.
// - Drives tanimoto_top i_Vector/i_Valid/o_Read directly.
// - Supports NUM_CH parallel channels, selectable data modes, and zeroed padding past VECTOR_WIDTH.

---
 rtl/tanimoto_pkg.sv | 37 +++
 rtl/lfsr32_galois.sv | 32 +++
 rtl/tanimoto_bist_src.sv | 160 ++++++++++++++++
 tb/tb_tanimoto_bist_src.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tanimoto_pkg.sv
// Shared encodings and constants for the tanimoto self-test source.
// Holds mode/state enums, LFSR polynomial, lane constant and the padding mask builder.
package tanimoto_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_IDX   = 2'd1,
    MODE_ONES  = 2'd2,
    MODE_ZEROS = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_THR  = 3'd1,
    ST_CNO  = 3'd2,
    ST_STRM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [31:0] LFSR_POLY     = 32'h80200003;
  localparam logic [31:0] LANE_K        = 32'h9E3779B9;
  localparam int          MAX_BUS_WIDTH = 4096;

  // Bits kept on a given sub-word; only the final sub-word of a vector is trimmed.
  function automatic logic [MAX_BUS_WIDTH-1:0] pad_mask(input int sub_idx, input int bus_w,
                                                        input int vec_w, input int sub_no);
    logic [MAX_BUS_WIDTH-1:0] m;
    int keep;
    keep = (sub_idx == sub_no - 1) ? vec_w - (sub_no - 1) * bus_w : bus_w;
    m = '0;
    for (int i = 0; i < MAX_BUS_WIDTH; i++) begin
      m[i] = (i < keep);
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR; load takes priority over step.
// A zero seed is forced to 1 so the register can never lock up.
module lfsr32_galois
  import tanimoto_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (step) begin
      q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_POLY : 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tanimoto_bist_src.sv
// On-chip stimulus source for tanimoto_top: threshold RAM load, compare-count
// handshake, then a valid/read stream of reference + compare vectors.
module tanimoto_bist_src
  import tanimoto_pkg::*;
#(
  parameter int BUS_WIDTH     = 512,
  parameter int VECTOR_WIDTH  = 920,
  parameter int SUB_VECTOR_NO = 2,
  parameter int NUM_CH        = 1,
  parameter int REF_VEC_NO    = 8,
  parameter int VEC_ID_WIDTH  = $clog2(VECTOR_WIDTH),
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_Start,
  input  logic [1:0]                    i_Mode,
  input  logic [31:0]                   i_Seed,
  input  logic [VEC_ID_WIDTH-1:0]       i_CmpVecNo,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic [CNT_WIDTH-1:0]          o_BRAM_Addr,
  output logic [CNT_WIDTH:0]            o_BRAM_Din,
  output logic                          o_BRAM_En,
  output logic                          o_BRAM_WrEn,
  output logic [VEC_ID_WIDTH-1:0]       o_CmpVectorNo,
  output logic                          o_CmpVectorNoValid,
  input  logic                          i_CmpVectorNoWack,
  output logic [NUM_CH*BUS_WIDTH-1:0]   o_Vector,
  output logic                          o_Valid,
  input  logic                          i_Read,
  output logic                          o_Last
);

  localparam int LANES = BUS_WIDTH / 32;
  localparam int SUB_W = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_VECTOR_NO - 1);

  localparam logic [MAX_BUS_WIDTH-1:0] MASK_FULL_W =
    pad_mask(0, BUS_WIDTH, VECTOR_WIDTH, SUB_VECTOR_NO + 1);
  localparam logic [MAX_BUS_WIDTH-1:0] MASK_LAST_W =
    pad_mask(SUB_VECTOR_NO - 1, BUS_WIDTH, VECTOR_WIDTH, SUB_VECTOR_NO);
  localparam logic [BUS_WIDTH-1:0] MASK_FULL = MASK_FULL_W[BUS_WIDTH-1:0];
  localparam logic [BUS_WIDTH-1:0] MASK_LAST = MASK_LAST_W[BUS_WIDTH-1:0];

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [CNT_WIDTH-1:0]    thr_q, thr_d;
  logic [VEC_ID_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]             total_q, total_d;
  logic [31:0]             word_q, word_d;
  logic [SUB_W-1:0]        sub_q, sub_d;
  logic                    lfsr_load, lfsr_step;
  logic [31:0]             base_seed;
  logic                    in_strm, in_thr;
  logic [BUS_WIDTH-1:0]    mask;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    word_d    = word_q;
    sub_d     = sub_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d   = ST_THR;
          mode_d    = mode_e'(i_Mode);
          cnt_d     = i_CmpVecNo;
          total_d   = (32'(REF_VEC_NO) + 32'(i_CmpVecNo)) * 32'(SUB_VECTOR_NO);
          thr_d     = '0;
          word_d    = '0;
          sub_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      ST_THR: begin
        thr_d = thr_q + 1'b1;
        if (thr_q == CNT_WIDTH'(VECTOR_WIDTH - 1)) state_d = ST_CNO;
      end
      ST_CNO: begin
        if (i_CmpVectorNoWack) state_d = ST_STRM;
      end
      ST_STRM: begin
        if (i_Read) begin
          lfsr_step = 1'b1;
          word_d    = word_q + 32'd1;
          sub_d     = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
          if (word_q == total_q - 32'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LFSR;
      thr_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      word_q  <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      word_q  <= word_d;
      sub_q   <= sub_d;
    end
  end

  assign in_thr             = (state_q == ST_THR);
  assign in_strm            = (state_q == ST_STRM);
  assign o_Busy             = in_thr || (state_q == ST_CNO) || in_strm;
  assign o_Done             = (state_q == ST_DONE);
  assign o_BRAM_En          = in_thr;
  assign o_BRAM_WrEn        = in_thr;
  assign o_BRAM_Addr        = in_thr ? thr_q : '0;
  assign o_BRAM_Din         = in_thr ? {1'b0, thr_q} : '0;
  assign o_CmpVectorNo      = cnt_q;
  assign o_CmpVectorNoValid = (state_q == ST_CNO);
  assign o_Valid            = in_strm;
  assign o_Last             = in_strm && (word_q == total_q - 32'd1);

  assign base_seed = (i_Seed == 32'd0) ? 32'd1 : i_Seed;
  assign mask      = (sub_q == SUB_LAST) ? MASK_LAST : MASK_FULL;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]            lfsr_q;
    logic [LANES-1:0][31:0] raw;

    lfsr32_galois u_lfsr (
      .clk  (clk),
      .rstn (rstn),
      .load (lfsr_load),
      .seed (base_seed + 32'(c)),
      .step (lfsr_step),
      .q    (lfsr_q)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [31:0] KMUL = 32'(k) * LANE_K;
      assign raw[k] = (mode_q == MODE_LFSR) ? (lfsr_q ^ KMUL) :
                      (mode_q == MODE_IDX)  ? word_q :
                      (mode_q == MODE_ONES) ? 32'hFFFF_FFFF : 32'd0;
    end

    assign o_Vector[c*BUS_WIDTH +: BUS_WIDTH] = in_strm ? (raw & mask) : '0;
  end

endmodule

// File: tb/tb_tanimoto_bist_src.sv
// Directed bench for tanimoto_bist_src: table of full runs plus hand sequences
// for seed-0 values, busy-start rejection and mid-stream reset.
module tb_tanimoto_bist_src;

  localparam int BW  = 512;
  localparam int VW  = 920;
  localparam int SUB = 2;
  localparam int NCH = 2;
  localparam int REF = 8;
  localparam int VID = 10;
  localparam int CW  = 10;

  logic              clk;
  logic              rstn;
  logic              i_Start;
  logic [1:0]        i_Mode;
  logic [31:0]       i_Seed;
  logic [VID-1:0]    i_CmpVecNo;
  logic              o_Busy, o_Done;
  logic [CW-1:0]     o_BRAM_Addr;
  logic [CW:0]       o_BRAM_Din;
  logic              o_BRAM_En, o_BRAM_WrEn;
  logic [VID-1:0]    o_CmpVectorNo;
  logic              o_CmpVectorNoValid;
  logic              i_CmpVectorNoWack;
  logic [NCH*BW-1:0] o_Vector;
  logic              o_Valid, i_Read, o_Last;

  tanimoto_bist_src #(
    .BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .SUB_VECTOR_NO(SUB), .NUM_CH(NCH),
    .REF_VEC_NO(REF), .VEC_ID_WIDTH(VID), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_Mode(i_Mode), .i_Seed(i_Seed),
    .i_CmpVecNo(i_CmpVecNo), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din), .o_BRAM_En(o_BRAM_En),
    .o_BRAM_WrEn(o_BRAM_WrEn), .o_CmpVectorNo(o_CmpVectorNo),
    .o_CmpVectorNoValid(o_CmpVectorNoValid), .i_CmpVectorNoWack(i_CmpVectorNoWack),
    .o_Vector(o_Vector), .o_Valid(o_Valid), .i_Read(i_Read), .o_Last(o_Last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [BW-1:0] exp_word(input int mode, input logic [31:0] lf,
                                             input logic [31:0] idx, input int sub);
    logic [BW-1:0] w;
    logic [31:0]   kc;
    for (int k = 0; k < BW / 32; k++) begin
      kc = 32'(k) * 32'h9E3779B9;
      case (mode)
        0:       w[32*k +: 32] = lf ^ kc;
        1:       w[32*k +: 32] = idx;
        2:       w[32*k +: 32] = 32'hFFFF_FFFF;
        default: w[32*k +: 32] = 32'd0;
      endcase
    end
    if (sub == SUB - 1)
      for (int b = VW - (SUB - 1) * BW; b < BW; b++) w[b] = 1'b0;
    return w;
  endfunction

  // Results of the most recent run
  int          r_thr_n, r_thr_err, r_en_after, r_busy_start;
  int          r_cno_hi, r_cno_after, r_cno_val;
  int          r_words, r_last_cnt, r_last_idx, r_data_err, r_stab_err;
  int          r_done, r_busy_done, r_done_after, r_ones0, r_ones1, r_timeout;
  logic [31:0] cap0 [3];
  logic [31:0] cap_l1w0, cap_ch1w0;

  task automatic run(input int mode, input logic [31:0] seed, input int cmp,
                     input int rd_pct, input int wack_d, input int abort_at);
    logic [31:0]       lf [NCH];
    logic [NCH*BW-1:0] prev_vec;
    int idx, sub, guard;
    bit rd, prev_stall;
    r_thr_n = 0; r_thr_err = 0; r_cno_hi = 0; r_words = 0; r_last_cnt = 0;
    r_last_idx = -1; r_data_err = 0; r_stab_err = 0; r_ones0 = -1; r_ones1 = -1;
    r_timeout = 0; r_done = 0; r_busy_done = 1; r_done_after = 1;
    for (int c = 0; c < NCH; c++) lf[c] = ((seed == 0) ? 32'd1 : seed) + 32'(c);

    i_Mode = 2'(mode); i_Seed = seed; i_CmpVecNo = VID'(cmp); i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    r_busy_start = int'(o_Busy);

    guard = 0;
    while (o_BRAM_WrEn && guard < 2000) begin
      if (o_BRAM_Addr != CW'(r_thr_n) || o_BRAM_Din != (CW+1)'(r_thr_n) || !o_BRAM_En)
        r_thr_err++;
      r_thr_n++;
      // A start arriving mid-run with different settings must have no effect
      if (r_thr_n == 10) begin
        i_Start = 1'b1; i_Mode = ~2'(mode); i_CmpVecNo = VID'(cmp + 3);
      end else begin
        i_Start = 1'b0; i_Mode = 2'(mode); i_CmpVecNo = VID'(cmp);
      end
      tick();
      guard++;
    end
    i_Start = 1'b0;
    r_en_after = int'(o_BRAM_En) + int'(o_BRAM_WrEn);
    r_cno_val  = int'(o_CmpVectorNo);

    for (int d = 0; d < wack_d; d++) begin
      if (o_CmpVectorNoValid) r_cno_hi++;
      tick();
    end
    if (o_CmpVectorNoValid) r_cno_hi++;
    i_CmpVectorNoWack = 1'b1;
    tick();
    i_CmpVectorNoWack = 1'b0;
    r_cno_after = int'(o_CmpVectorNoValid);

    idx = 0; sub = 0; guard = 0; prev_stall = 0; prev_vec = '0;
    while (o_Valid && guard < 20000 && !(abort_at >= 0 && idx == abort_at)) begin
      for (int c = 0; c < NCH; c++)
        if (o_Vector[c*BW +: BW] !== exp_word(mode, lf[c], 32'(idx), sub)) r_data_err++;
      if (prev_stall && o_Vector !== prev_vec) r_stab_err++;
      if (idx == 0) begin
        r_ones0 = $countones(o_Vector[BW-1:0]);
        cap_l1w0 = o_Vector[63:32];
        cap_ch1w0 = o_Vector[BW+31:BW];
      end
      if (idx == 1) r_ones1 = $countones(o_Vector[BW-1:0]);
      if (idx < 3) cap0[idx] = o_Vector[31:0];
      rd = (rd_pct >= 100) || ($urandom_range(0, 99) < rd_pct);
      i_Read = rd;
      if (rd && o_Last) begin r_last_cnt++; r_last_idx = idx; end
      prev_vec = o_Vector;
      prev_stall = !rd;
      tick();
      if (rd) begin
        for (int c = 0; c < NCH; c++) lf[c] = lfsr_next(lf[c]);
        idx++;
        sub = (sub == SUB - 1) ? 0 : sub + 1;
      end
      guard++;
    end
    i_Read = 1'b0;
    r_words = idx;
    if (guard >= 20000) r_timeout = 1;
    if (abort_at < 0) begin
      r_done = int'(o_Done);
      r_busy_done = int'(o_Busy);
      tick();
      r_done_after = int'(o_Done);
    end
  endtask

  typedef struct {
    int          mode;
    logic [31:0] seed;
    int          cmp;
    int          rd_pct;
    int          wack;
    int          words;
    int          ones0;
    int          ones1;
  } vec_t;

  vec_t tbl [6];
  int   seen_done;

  initial begin
    tbl[0] = '{3, 32'd5,          3,   100, 0, 22,  0,   0};
    tbl[1] = '{1, 32'd1,          128, 100, 5, 272, 0,   13};
    tbl[2] = '{2, 32'd7,          4,   100, 1, 24,  512, 408};
    tbl[3] = '{0, 32'h1234_5678,  20,  50,  2, 56,  -1,  -1};
    tbl[4] = '{1, 32'd9,          0,   50,  0, 16,  0,   13};
    tbl[5] = '{2, 32'd0,          0,   100, 3, 16,  512, 408};

    rstn = 1'b0; i_Start = 1'b0; i_Mode = '0; i_Seed = '0; i_CmpVecNo = '0;
    i_CmpVectorNoWack = 1'b0; i_Read = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy", o_Busy, 0);
    chk("rst_ctrl", {o_Done, o_BRAM_En, o_BRAM_WrEn, o_CmpVectorNoValid, o_Valid, o_Last}, 0);
    chk("rst_data", {o_BRAM_Addr, o_BRAM_Din, o_CmpVectorNo}, 0);
    chk("rst_vec", |o_Vector, 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].mode, tbl[i].seed, tbl[i].cmp, tbl[i].rd_pct, tbl[i].wack, -1);
      chk($sformatf("v%0d_busy_start", i), r_busy_start, 1);
      chk($sformatf("v%0d_thr_writes", i), r_thr_n, VW);
      chk($sformatf("v%0d_thr_data", i), r_thr_err, 0);
      chk($sformatf("v%0d_thr_off", i), r_en_after, 0);
      chk($sformatf("v%0d_cno_val", i), r_cno_val, tbl[i].cmp);
      chk($sformatf("v%0d_cno_hi", i), r_cno_hi, tbl[i].wack + 1);
      chk($sformatf("v%0d_cno_drop", i), r_cno_after, 0);
      chk($sformatf("v%0d_words", i), r_words, tbl[i].words);
      chk($sformatf("v%0d_last_cnt", i), r_last_cnt, 1);
      chk($sformatf("v%0d_last_idx", i), r_last_idx, tbl[i].words - 1);
      chk($sformatf("v%0d_data", i), r_data_err, 0);
      chk($sformatf("v%0d_stable", i), r_stab_err, 0);
      chk($sformatf("v%0d_timeout", i), r_timeout, 0);
      chk($sformatf("v%0d_done", i), r_done, 1);
      chk($sformatf("v%0d_busy_done", i), r_busy_done, 0);
      chk($sformatf("v%0d_done_1cyc", i), r_done_after, 0);
      if (tbl[i].ones0 >= 0) chk($sformatf("v%0d_ones_even", i), r_ones0, tbl[i].ones0);
      if (tbl[i].ones1 >= 0) chk($sformatf("v%0d_ones_odd", i), r_ones1, tbl[i].ones1);
    end

    // Seed 0 acts as seed 1; hand-stepped LFSR values; channel 1 seeded one higher
    run(0, 32'd0, 0, 100, 0, -1);
    chk("s0_words", r_words, 16);
    chk("s0_w0_l0", cap0[0], 32'h0000_0001);
    chk("s0_w1_l0", cap0[1], 32'h8020_0003);
    chk("s0_w2_l0", cap0[2], 32'hC030_0002);
    chk("s0_w0_l1", cap_l1w0, 32'h9E37_79B8);
    chk("s0_ch1_w0", cap_ch1w0, 32'h0000_0002);

    // Reset partway through the stream, then repeat the identical run
    run(0, 32'hACE1_0001, 128, 100, 0, 50);
    chk("abort_at", r_words, 50);
    rstn = 1'b0;
    tick();
    chk("abort_ctrl", {o_Busy, o_Done, o_BRAM_En, o_BRAM_WrEn, o_CmpVectorNoValid, o_Valid, o_Last}, 0);
    chk("abort_data", {o_BRAM_Addr, o_BRAM_Din, o_CmpVectorNo}, 0);
    chk("abort_vec", |o_Vector, 0);
    rstn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_Done) seen_done++;
      tick();
    end
    chk("abort_no_done", seen_done, 0);
    run(0, 32'hACE1_0001, 128, 100, 0, -1);
    chk("rerun_words", r_words, 272);
    chk("rerun_data", r_data_err, 0);
    chk("rerun_done", r_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
